// File: rtl/rgb_frame_writer_pkg.sv
// Shared types and constants for the RGB frame writer.
// State encoding, pixel field positions, counter width, and the RGB565 packing helper.
package frame_writer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int PIX_W = 24;
   localparam int R_MSB = 23;
   localparam int R_LSB = 16;
   localparam int G_MSB = 15;
   localparam int G_LSB = 8;
   localparam int B_MSB = 7;
   localparam int B_LSB = 0;
   localparam int CNT_W = 16;

   // Keep the top bits of each colour and zero-extend the 16-bit result to pixel width
   function automatic logic [PIX_W-1:0] to_rgb565(input logic [PIX_W-1:0] p);
      return {8'd0, p[R_MSB -: 5], p[G_MSB -: 6], p[B_MSB -: 5]};
   endfunction

endpackage

// File: rtl/rgb_frame_writer_if.sv
// Pixel-in / BRAM-write-out bundle for rgb_frame_writer.
// slave = the writer itself, master = whatever feeds pixels and watches writes.
interface rgb_frame_writer_if #(
   parameter int ADDR_WIDTH = 19
);
   import frame_writer_pkg::*;

   logic [PIX_W-1:0]      i_rgb_data;
   logic                  i_rgb_valid;
   logic                  i_frame_start;
   logic                  o_wr_en;
   logic [ADDR_WIDTH-1:0] o_wr_addr;
   logic [PIX_W-1:0]      o_wr_data;
   logic [CNT_W-1:0]      o_x;
   logic [CNT_W-1:0]      o_y;
   logic                  o_frame_done;
   logic                  o_frame_err;
   logic [CNT_W-1:0]      o_drop_cnt;
   logic                  o_busy;

   modport slave (
      input  i_rgb_data, i_rgb_valid, i_frame_start,
      output o_wr_en, o_wr_addr, o_wr_data, o_x, o_y,
             o_frame_done, o_frame_err, o_drop_cnt, o_busy
   );

   modport master (
      output i_rgb_data, i_rgb_valid, i_frame_start,
      input  o_wr_en, o_wr_addr, o_wr_data, o_x, o_y,
             o_frame_done, o_frame_err, o_drop_cnt, o_busy
   );

endinterface

// File: rtl/rgb_frame_writer_raster_counter.sv
// Raster position tracker: x, y and linear address advanced together (no multiplier).
// The o_x/o_y/o_addr outputs are the position of the pixel accepted this cycle:
// a same-cycle clear makes that pixel land at the origin.
module raster_counter
   import frame_writer_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int ADDR_WIDTH = 19
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_adv,
   output logic [CNT_W-1:0]      o_x,
   output logic [CNT_W-1:0]      o_y,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_last
);

   logic [CNT_W-1:0]      r_x;
   logic [CNT_W-1:0]      r_y;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  w_eol;

   assign o_x    = i_clr ? '0 : r_x;
   assign o_y    = i_clr ? '0 : r_y;
   assign o_addr = i_clr ? '0 : r_addr;
   assign w_eol  = (o_x == CNT_W'(H_ACTIVE - 1));
   assign o_last = w_eol && (o_y == CNT_W'(V_ACTIVE - 1));

   // Step from the effective position; wrap to origin after the frame's last pixel
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
      end else if (i_adv) begin
         if (o_last) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
         end else if (w_eol) begin
            r_x    <= '0;
            r_y    <= o_y + CNT_W'(1);
            r_addr <= o_addr + ADDR_WIDTH'(1);
         end else begin
            r_x    <= o_x + CNT_W'(1);
            r_y    <= o_y;
            r_addr <= o_addr + ADDR_WIDTH'(1);
         end
      end else if (i_clr) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
      end
   end

endmodule

// File: rtl/rgb_frame_writer.sv
// rgb_frame_writer: writes one pixel per i_rgb_valid into a frame-buffer BRAM port in
// raster order, framed by i_frame_start, with abort and stray-pixel reporting.
// Build option: RGB_FRAME_WRITER_RGB565_EN packs write data as zero-extended RGB565;
// otherwise the 24-bit pixel is written unchanged. Latency is one cycle either way.
module rgb_frame_writer
   import frame_writer_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int ADDR_WIDTH = 19
) (
   input  logic               i_clk,
   input  logic               i_rst,
   rgb_frame_writer_if.slave  bus
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_start;
   logic                  w_accept;
   logic                  w_drop;
   logic                  w_last;
   logic                  w_wr_last;
   logic [CNT_W-1:0]      w_cx;
   logic [CNT_W-1:0]      w_cy;
   logic [ADDR_WIDTH-1:0] w_caddr;
   logic [PIX_W-1:0]      w_pix;

   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [PIX_W-1:0]      r_wr_data;
   logic [CNT_W-1:0]      r_x;
   logic [CNT_W-1:0]      r_y;
   logic                  r_done;
   logic                  r_err;
   logic [CNT_W-1:0]      r_drop;

   // A start in DONE is ignored; only IDLE/WRITE can (re)arm
   assign w_start   = bus.i_frame_start && (r_state != DONE);
   assign w_accept  = bus.i_rgb_valid && ((r_state == WRITE) || w_start);
   assign w_drop    = bus.i_rgb_valid && !w_accept;
   assign w_wr_last = w_accept && w_last;

`ifdef RGB_FRAME_WRITER_RGB565_EN
   assign w_pix = to_rgb565(bus.i_rgb_data);
`else
   assign w_pix = bus.i_rgb_data;
`endif

   raster_counter #(
      .H_ACTIVE   (H_ACTIVE),
      .V_ACTIVE   (V_ACTIVE),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_start),
      .i_adv  (w_accept),
      .o_x    (w_cx),
      .o_y    (w_cy),
      .o_addr (w_caddr),
      .o_last (w_last)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state: a restart in WRITE stays in WRITE; last accepted pixel ends the frame
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, WRITE: begin
            if (w_wr_last)    w_state_nxt = DONE;
            else if (w_start) w_state_nxt = WRITE;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Registered write port, pulses and saturating drop counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_drop    <= '0;
      end else begin
         r_wr_en <= w_accept;
         r_done  <= w_wr_last;
         r_err   <= bus.i_frame_start && (r_state == WRITE);
         if (w_accept) begin
            r_wr_addr <= w_caddr;
            r_wr_data <= w_pix;
            r_x       <= w_cx;
            r_y       <= w_cy;
         end
         if (w_drop && (r_drop != '1)) r_drop <= r_drop + CNT_W'(1);
      end
   end

   assign bus.o_wr_en      = r_wr_en;
   assign bus.o_wr_addr    = r_wr_addr;
   assign bus.o_wr_data    = r_wr_data;
   assign bus.o_x          = r_x;
   assign bus.o_y          = r_y;
   assign bus.o_frame_done = r_done;
   assign bus.o_frame_err  = r_err;
   assign bus.o_drop_cnt   = r_drop;
   assign bus.o_busy       = (r_state == WRITE);

endmodule
